// File: rtl/pc_pkg.sv
// Shared constants for the PC / fetch-redirect unit: counter encodings,
// allocation values, control states and BTB geometry helpers.
package pc_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam logic [1:0] CTR_ALLOC_BR  = WT;
  localparam logic [1:0] CTR_ALLOC_JMP = ST;

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  function automatic int unsigned btb_idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned btb_tag_w(input int unsigned xlen, input int unsigned depth);
    return xlen - $clog2(depth) - 2;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped BTB: combinational lookup, synchronous update with 2-bit
// saturating counters, valid bits cleared asynchronously by reset.
module pc_btb
  import pc_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_rd_pc,
  output logic            o_rd_taken,
  output logic [XLEN-1:0] o_rd_target,
  input  logic            i_wr_en,
  input  logic            i_wr_jump,
  input  logic            i_wr_taken,
  input  logic [XLEN-1:0] i_wr_pc,
  input  logic [XLEN-1:0] i_wr_target
);

  localparam int unsigned IDX  = btb_idx_w(DEPTH);
  localparam int unsigned TAGW = btb_tag_w(XLEN, DEPTH);

  logic [DEPTH-1:0]           vld_q;
  logic [DEPTH-1:0][TAGW-1:0] tag_q;
  logic [DEPTH-1:0][XLEN-1:0] tgt_q;
  logic [DEPTH-1:0][1:0]      ctr_q;

  logic [IDX-1:0]  ridx, widx;
  logic [TAGW-1:0] rtag, wtag;
  logic            rd_hit, wr_hit, wr_upd;
  logic [1:0]      ctr_nxt;
  logic            unused_lsb;

  assign ridx       = i_rd_pc[IDX+1:2];
  assign rtag       = i_rd_pc[XLEN-1:IDX+2];
  assign widx       = i_wr_pc[IDX+1:2];
  assign wtag       = i_wr_pc[XLEN-1:IDX+2];
  assign unused_lsb = ^{i_rd_pc[1:0], i_wr_pc[1:0]};

  assign rd_hit      = vld_q[ridx] && (tag_q[ridx] == rtag);
  assign o_rd_taken  = rd_hit && ctr_q[ridx][1];
  assign o_rd_target = o_rd_taken ? tgt_q[ridx] : '0;

  assign wr_hit = vld_q[widx] && (tag_q[widx] == wtag);
  // A not-taken miss leaves the entry alone; everything else rewrites it.
  assign wr_upd = i_wr_en && (wr_hit || i_wr_taken);

  always_comb begin
    ctr_nxt = i_wr_jump ? CTR_ALLOC_JMP : CTR_ALLOC_BR;
    if (wr_hit && !i_wr_jump) begin
      if (i_wr_taken) ctr_nxt = (ctr_q[widx] == ST)  ? ST  : ctr_q[widx] + 2'd1;
      else            ctr_nxt = (ctr_q[widx] == SNT) ? SNT : ctr_q[widx] - 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    vld_q <= '0;
    else if (wr_upd) vld_q[widx] <= 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (wr_upd) begin
      tag_q[widx] <= wtag;
      ctr_q[widx] <= ctr_nxt;
      if (i_wr_taken) tgt_q[widx] <= i_wr_target;
    end
  end

endmodule

// File: rtl/pc_predict.sv
// PC register and fetch-redirect control: BTB prediction, late resolve
// from execute, mispredict redirect, and redirects deferred across stalls.
module pc_predict
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int unsigned     BTB_DEPTH  = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_res_vld,
  input  logic            i_res_branch,
  input  logic            i_res_jump,
  input  logic            i_res_taken,
  input  logic [XLEN-1:0] i_res_pc,
  input  logic [XLEN-1:0] i_res_target,
  input  logic            i_res_pred_taken,
  input  logic [XLEN-1:0] i_res_pred_target,
  output logic [XLEN-1:0] o_imem_raddr,
  output logic [XLEN-1:0] o_nxt_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  output logic            o_flush,
  output logic            o_misalign
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pend_q;
  logic            mis_q;

  logic            res_ok, act_taken, mispred, bad_tgt, redir_ok;
  logic [XLEN-1:0] redir_addr;

  // Resolves are only honoured in RUN: in PEND they are wrong-path.
  assign res_ok    = i_res_vld && (i_res_branch || i_res_jump) && (state_q == S_RUN);
  assign act_taken = i_res_jump || i_res_taken;
  assign mispred   = res_ok && ((act_taken != i_res_pred_taken) ||
                                (act_taken && (i_res_target != i_res_pred_target)));
  assign redir_addr = act_taken ? i_res_target : i_res_pc + XLEN'(4);
  assign bad_tgt    = mispred && (redir_addr[1:0] != 2'b00);
  assign redir_ok   = mispred && !bad_tgt;

  pc_btb #(.XLEN(XLEN), .DEPTH(BTB_DEPTH)) u_btb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rd_pc     (pc_q),
    .o_rd_taken  (o_pred_taken),
    .o_rd_target (o_pred_target),
    .i_wr_en     (res_ok && !bad_tgt),
    .i_wr_jump   (i_res_jump),
    .i_wr_taken  (act_taken),
    .i_wr_pc     (i_res_pc),
    .i_wr_target (i_res_target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    o_flush = 1'b0;
    case (state_q)
      S_WAIT: begin
        o_flush = 1'b1;
        state_d = S_RUN;
      end
      S_PEND: begin
        if (!i_stall) begin
          pc_d    = pend_q;
          o_flush = 1'b1;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
        if (i_stall) begin
          if (redir_ok) state_d = S_PEND;
        end else if (redir_ok) begin
          pc_d    = redir_addr;
          o_flush = 1'b1;
        end else if (bad_tgt) begin
          pc_d = pc_q;
        end else if (o_pred_taken) begin
          pc_d = o_pred_target;
        end else begin
          pc_d = pc_q + XLEN'(4);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_WAIT;
      pc_q    <= RESET_ADDR;
      pend_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= bad_tgt;
      if (state_q == S_RUN && i_stall && redir_ok) pend_q <= redir_addr;
    end
  end

  assign o_imem_raddr = pc_q;
  assign o_nxt_pc     = pc_d;
  assign o_misalign   = mis_q;

endmodule

// File: tb/tb_pc_predict.sv
// Vector table plus hand-written stall/misalign/reset sequences; expected
// outputs are queued at drive time and compared by a negedge monitor.
module tb_pc_predict;

  localparam logic [4:0] C_ST  = 5'b10000;
  localparam logic [4:0] C_BR  = 5'b01100;
  localparam logic [4:0] C_JMP = 5'b01010;
  localparam logic [4:0] C_TK  = 5'b00001;
  localparam logic [2:0] E_FL  = 3'b100;
  localparam logic [2:0] E_PT  = 3'b010;
  localparam logic [2:0] E_MS  = 3'b001;

  typedef struct {
    string       nm;
    logic [31:0] addr, nxt;
    logic        flush, ptk;
    logic [31:0] ptgt;
    logic        mis;
  } exp_t;

  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] pc, tgt;
    logic        ptk;
    logic [31:0] ptgt;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0, res_vld = 1'b0, res_br = 1'b0, res_jmp = 1'b0, res_tk = 1'b0;
  logic [31:0] res_pc = '0, res_tgt = '0, res_ptgt = '0;
  logic        res_ptk = 1'b0;
  logic [31:0] imem_raddr, nxt_pc, pred_target;
  logic        pred_taken, flush, misalign;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  pc_predict #(.XLEN(32), .RESET_ADDR(32'h0), .BTB_DEPTH(16)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_stall           (stall),
    .i_res_vld         (res_vld),
    .i_res_branch      (res_br),
    .i_res_jump        (res_jmp),
    .i_res_taken       (res_tk),
    .i_res_pc          (res_pc),
    .i_res_target      (res_tgt),
    .i_res_pred_taken  (res_ptk),
    .i_res_pred_target (res_ptgt),
    .o_imem_raddr      (imem_raddr),
    .o_nxt_pc          (nxt_pc),
    .o_pred_taken      (pred_taken),
    .o_pred_target     (pred_target),
    .o_flush           (flush),
    .o_misalign        (misalign)
  );

  function automatic vec_t V(input string nm, input logic [4:0] ctl,
                             input logic [31:0] pc, input logic [31:0] tgt,
                             input logic ptk, input logic [31:0] ptgt,
                             input logic [31:0] a, input logic [31:0] n,
                             input logic [2:0] f, input logic [31:0] pt);
    vec_t v;
    v.ctl = ctl; v.pc = pc; v.tgt = tgt; v.ptk = ptk; v.ptgt = ptgt;
    v.e.nm = nm; v.e.addr = a; v.e.nxt = n;
    v.e.flush = f[2]; v.e.ptk = f[1]; v.e.mis = f[0]; v.e.ptgt = pt;
    return v;
  endfunction

  task automatic check(input exp_t e);
    n_vec++;
    if (imem_raddr !== e.addr) begin
      n_err++; $display("FAIL %s raddr got %h want %h", e.nm, imem_raddr, e.addr);
    end
    if (nxt_pc !== e.nxt) begin
      n_err++; $display("FAIL %s nxt_pc got %h want %h", e.nm, nxt_pc, e.nxt);
    end
    if (flush !== e.flush) begin
      n_err++; $display("FAIL %s flush got %b want %b", e.nm, flush, e.flush);
    end
    if (pred_taken !== e.ptk) begin
      n_err++; $display("FAIL %s pred_taken got %b want %b", e.nm, pred_taken, e.ptk);
    end
    if (pred_target !== e.ptgt) begin
      n_err++; $display("FAIL %s pred_target got %h want %h", e.nm, pred_target, e.ptgt);
    end
    if (misalign !== e.mis) begin
      n_err++; $display("FAIL %s misalign got %b want %b", e.nm, misalign, e.mis);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input vec_t v);
    stall   = v.ctl[4];
    res_vld = v.ctl[3];
    res_br  = v.ctl[2];
    res_jmp = v.ctl[1];
    res_tk  = v.ctl[0];
    res_pc  = v.pc; res_tgt = v.tgt; res_ptk = v.ptk; res_ptgt = v.ptgt;
    sb.push_back(v.e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) check(sb.pop_front());
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t er;
    er.nm = "reset"; er.addr = 32'h0; er.nxt = 32'h0; er.flush = 1'b1;
    er.ptk = 1'b0; er.ptgt = 32'h0; er.mis = 1'b0;

    tbl.push_back(V("wait",      5'd0,          32'h0,        32'h0,    0, 32'h0,    32'h00, 32'h00,  E_FL, 32'h0));
    tbl.push_back(V("run0",      5'd0,          32'h0,        32'h0,    0, 32'h0,    32'h00, 32'h04,  3'd0, 32'h0));
    tbl.push_back(V("seq4",      5'd0,          32'h0,        32'h0,    0, 32'h0,    32'h04, 32'h08,  3'd0, 32'h0));
    tbl.push_back(V("seq8",      5'd0,          32'h0,        32'h0,    0, 32'h0,    32'h08, 32'h0C,  3'd0, 32'h0));
    tbl.push_back(V("seqC",      5'd0,          32'h0,        32'h0,    0, 32'h0,    32'h0C, 32'h10,  3'd0, 32'h0));
    tbl.push_back(V("seq10",     5'd0,          32'h0,        32'h0,    0, 32'h0,    32'h10, 32'h14,  3'd0, 32'h0));
    tbl.push_back(V("br_mp_tk",  C_BR|C_TK,     32'h10,       32'h40,   0, 32'h0,    32'h14, 32'h40,  E_FL, 32'h0));
    tbl.push_back(V("at40",      5'd0,          32'h0,        32'h0,    0, 32'h0,    32'h40, 32'h44,  3'd0, 32'h0));
    tbl.push_back(V("jal_mp",    C_JMP,         32'h200,      32'h10,   0, 32'h0,    32'h44, 32'h10,  E_FL, 32'h0));
    tbl.push_back(V("btb_hit",   5'd0,          32'h0,        32'h0,    0, 32'h0,    32'h10, 32'h40,  E_PT, 32'h40));
    tbl.push_back(V("br_mp_nt",  C_BR,          32'h10,       32'h40,   1, 32'h40,   32'h40, 32'h14,  E_FL, 32'h0));
    tbl.push_back(V("br_ok_nt",  C_BR,          32'h10,       32'h40,   0, 32'h0,    32'h14, 32'h18,  3'd0, 32'h0));
    tbl.push_back(V("jal_to10",  C_JMP,         32'h300,      32'h10,   0, 32'h0,    32'h18, 32'h10,  E_FL, 32'h0));
    tbl.push_back(V("ctr_low",   5'd0,          32'h0,        32'h0,    0, 32'h0,    32'h10, 32'h14,  3'd0, 32'h0));
    tbl.push_back(V("jal_to300", C_JMP,         32'h504,      32'h300,  0, 32'h0,    32'h14, 32'h300, E_FL, 32'h0));
    tbl.push_back(V("btb_jmp",   5'd0,          32'h0,        32'h0,    0, 32'h0,    32'h300,32'h10,  E_PT, 32'h10));
    tbl.push_back(V("jmp_ok",    C_JMP|C_TK,    32'h300,      32'h10,   1, 32'h10,   32'h10, 32'h14,  3'd0, 32'h0));
    tbl.push_back(V("wrap",      C_BR,          32'hFFFFFFFC, 32'h1234, 1, 32'h1234, 32'h14, 32'h0,   E_FL, 32'h0));
    tbl.push_back(V("tgt_mp",    C_JMP|C_TK,    32'h300,      32'h80,   1, 32'h10,   32'h00, 32'h80,  E_FL, 32'h0));
    tbl.push_back(V("at80",      5'd0,          32'h0,        32'h0,    0, 32'h0,    32'h80, 32'h84,  3'd0, 32'h0));

    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check(er);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // mispredict captured under a 3-cycle stall, second resolve is wrong-path
    step(V("st_cap",    C_ST|C_BR|C_TK, 32'h60,  32'h100, 0, 32'h0, 32'h84,  32'h84,  3'd0, 32'h0));
    step(V("st_ign",    C_ST|C_BR|C_TK, 32'h64,  32'h200, 0, 32'h0, 32'h84,  32'h84,  3'd0, 32'h0));
    step(V("st_hold",   C_ST,           32'h0,   32'h0,   0, 32'h0, 32'h84,  32'h84,  3'd0, 32'h0));
    step(V("st_rel",    5'd0,           32'h0,   32'h0,   0, 32'h0, 32'h84,  32'h100, E_FL, 32'h0));
    step(V("to60",      C_JMP,          32'h700, 32'h60,  0, 32'h0, 32'h100, 32'h60,  E_FL, 32'h0));
    step(V("mp_over_bt",C_JMP,          32'h708, 32'h64,  0, 32'h0, 32'h60,  32'h64,  E_FL|E_PT, 32'h100));
    step(V("no_wr64",   5'd0,           32'h0,   32'h0,   0, 32'h0, 32'h64,  32'h68,  3'd0, 32'h0));

    // misaligned jalr target
    step(V("mis_res",   C_JMP,          32'h88,  32'h102, 0, 32'h0, 32'h68,  32'h68,  3'd0, 32'h0));
    step(V("mis_pulse", 5'd0,           32'h0,   32'h0,   0, 32'h0, 32'h68,  32'h6C,  E_MS, 32'h0));
    step(V("mis_done",  C_JMP,          32'h70C, 32'h88,  0, 32'h0, 32'h6C,  32'h88,  E_FL, 32'h0));
    step(V("no_wr88",   5'd0,           32'h0,   32'h0,   0, 32'h0, 32'h88,  32'h8C,  3'd0, 32'h0));

    // reset asserted while a redirect is pending
    step(V("pend_cap",  C_ST|C_BR|C_TK, 32'h8C,  32'h40,  0, 32'h0, 32'h8C,  32'h8C,  3'd0, 32'h0));
    step(V("pend_see",  C_ST,           32'h0,   32'h0,   0, 32'h0, 32'h8C,  32'h8C,  E_PT, 32'h40));
    #2 rst_n = 1'b0;
    #1 er.nm = "rst_mid"; check(er);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(V("rwait",     5'd0,           32'h0,   32'h0,   0, 32'h0, 32'h00,  32'h00,  E_FL, 32'h0));
    step(V("rrun0",     5'd0,           32'h0,   32'h0,   0, 32'h0, 32'h00,  32'h04,  3'd0, 32'h0));
    step(V("r_to8C",    C_JMP,          32'h3C,  32'h8C,  0, 32'h0, 32'h04,  32'h8C,  E_FL, 32'h0));
    step(V("r_clear",   5'd0,           32'h0,   32'h0,   0, 32'h0, 32'h8C,  32'h90,  3'd0, 32'h0));

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain queue has %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
